// File: rtl/fetch_sequencer.sv
// Fetch stage: owns the PC, issues single-beat instruction reads, hands each word to decode
// over valid/ready and resolves format-2'b10 branches against the last ALU result.
module fetch_sequencer #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned DATA_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_rvalid,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic [DATA_W-1:0]  last_alu_result,
    output logic               branch_taken,
    output logic [ADDR_W-1:0]  pc
);

    if (INSTR_W < ADDR_W + 4) begin : g_bad_width
        $error("fetch_sequencer: INSTR_W must be >= ADDR_W + 4");
    end

    typedef enum logic [1:0] {StFetch, StWait, StIssue} state_e;

    state_e            state;
    logic [1:0]        br_format;
    logic [1:0]        br_cond;
    logic [ADDR_W-1:0] br_target;
    logic              cond_met;
    logic              branch_hit;
    logic [ADDR_W-1:0] next_pc;

    // Branch resolution on the word currently offered to decode.
    always_comb begin
        br_format = instr[1:0];
        br_cond   = instr[3:2];
        br_target = instr[ADDR_W+3:4];
        cond_met  = 1'b0;
        case (br_cond)
            2'b00:   cond_met = (last_alu_result == DATA_W'(0));
            2'b01:   cond_met = (last_alu_result == DATA_W'(1));
            2'b10:   cond_met = (last_alu_result == DATA_W'(2));
            default: cond_met = 1'b1;
        endcase
        branch_hit = (br_format == 2'b10) && cond_met;
        next_pc    = branch_hit ? br_target : pc + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= StFetch;
            pc           <= RESET_PC;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            instr_valid  <= 1'b0;
            instr        <= '0;
            instr_pc     <= '0;
            branch_taken <= 1'b0;
        end else begin
            case (state)
                StFetch: begin
                    mem_req      <= 1'b1;
                    mem_addr     <= pc;
                    branch_taken <= 1'b0;
                    state        <= StWait;
                end
                StWait: begin
                    mem_req <= 1'b0;
                    if (mem_rvalid) begin
                        instr       <= mem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= StIssue;
                    end
                end
                StIssue: begin
                    // Responses seen here are stray and must not disturb the held word.
                    if (instr_ready) begin
                        instr_valid  <= 1'b0;
                        pc           <= next_pc;
                        branch_taken <= branch_hit;
                        state        <= StFetch;
                    end
                end
                default: state <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, backpressure, branches, wrap,
// mid-flight reset and variable memory latency.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic [15:0] last_alu_result;
    logic        branch_taken;
    logic [7:0]  pc;

    logic        w_reset;
    logic        w_mem_req;
    logic [7:0]  w_mem_addr;
    logic        w_mem_rvalid;
    logic        w_instr_valid;
    logic [15:0] w_instr;
    logic [7:0]  w_instr_pc;
    logic        w_branch_taken;
    logic [7:0]  w_pc;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_sequencer #(
        .ADDR_W(8), .INSTR_W(16), .DATA_W(16), .RESET_PC(8'h00)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .last_alu_result(last_alu_result),
        .branch_taken(branch_taken), .pc(pc)
    );

    fetch_sequencer #(
        .ADDR_W(8), .INSTR_W(16), .DATA_W(16), .RESET_PC(8'hFF)
    ) dut_wrap (
        .clk(clk), .reset(w_reset),
        .mem_req(w_mem_req), .mem_addr(w_mem_addr),
        .mem_rvalid(w_mem_rvalid), .mem_rdata(16'h1230),
        .instr_valid(w_instr_valid), .instr_ready(1'b1),
        .instr(w_instr), .instr_pc(w_instr_pc),
        .last_alu_result(16'h0000),
        .branch_taken(w_branch_taken), .pc(w_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full instruction: wait for the request, answer after lat cycles, hold decode off
    // for hold cycles (with stray responses), then handshake and check the redirect.
    task automatic fetch_one(input logic [7:0] exp_addr, input int lat, input logic [15:0] data,
                             input int hold, input logic [15:0] alu, input logic exp_bt,
                             input logic [7:0] exp_next, output int req_cyc);
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (i == 0) check("bt_one_cycle", 32'(branch_taken), 32'd0);
            if (mem_req) found = 1;
        end
        check("req_seen", 32'(found), 32'd1);
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        req_cyc = cyc;
        if (lat > 0) repeat (lat) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("instr_valid", 32'(instr_valid), 32'd1);
        check("instr", 32'(instr), 32'(data));
        check("instr_pc", 32'(instr_pc), 32'(exp_addr));
        check("mem_req_low", 32'(mem_req), 32'd0);
        for (int h = 0; h < hold; h++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = ~data;
            @(negedge clk);
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_instr", 32'(instr), 32'(data));
            check("hold_ipc", 32'(instr_pc), 32'(exp_addr));
            check("hold_noreq", 32'(mem_req), 32'd0);
            check("hold_pc", 32'(pc), 32'(exp_addr));
        end
        mem_rvalid      = 1'b0;
        instr_ready     = 1'b1;
        last_alu_result = alu;
        @(negedge clk);
        instr_ready = 1'b0;
        check("valid_drop", 32'(instr_valid), 32'd0);
        check("branch_taken", 32'(branch_taken), 32'(exp_bt));
        check("next_pc", 32'(pc), 32'(exp_next));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  c0, c1;
        bit  found;
        int  nreq;
        logic [7:0] waddr [0:3];

        reset = 1'b0;
        w_reset = 1'b0;
        w_mem_rvalid = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 16'h0;
        instr_ready = 1'b0;
        last_alu_result = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_bt", 32'(branch_taken), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_ipc", 32'(instr_pc), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_wrap_pc", 32'(w_pc), 32'hFF);
        reset = 1'b1;

        // Sequential fetch, then backpressure with stray responses.
        fetch_one(8'h00, 1, 16'h1110, 0, 16'h0, 1'b0, 8'h01, c0);
        fetch_one(8'h01, 1, 16'h2220, 0, 16'h0, 1'b0, 8'h02, c0);
        fetch_one(8'h02, 1, 16'h3330, 0, 16'h0, 1'b0, 8'h03, c0);
        fetch_one(8'h03, 0, 16'h4440, 5, 16'h0, 1'b0, 8'h04, c0);
        // Branch conditions; target field is instr[11:4].
        fetch_one(8'h04, 1, 16'h0A32, 0, 16'h0000, 1'b1, 8'hA3, c0);
        fetch_one(8'hA3, 1, 16'h004E, 0, 16'h0007, 1'b1, 8'h04, c0);
        fetch_one(8'h04, 1, 16'h0A32, 0, 16'h0005, 1'b0, 8'h05, c0);
        fetch_one(8'h05, 1, 16'h0A36, 0, 16'h0001, 1'b1, 8'hA3, c0);
        fetch_one(8'hA3, 1, 16'h0B2A, 0, 16'h0002, 1'b1, 8'hB2, c0);
        fetch_one(8'hB2, 1, 16'h0B2A, 0, 16'h0001, 1'b0, 8'hB3, c0);
        fetch_one(8'hB3, 1, 16'h0C3E, 0, 16'h0007, 1'b1, 8'hC3, c0);
        fetch_one(8'hC3, 1, 16'h0FF0, 0, 16'h0000, 1'b0, 8'hC4, c0);
        fetch_one(8'hC4, 1, 16'h0A32, 0, 16'h0100, 1'b0, 8'hC5, c0);
        fetch_one(8'hC5, 1, 16'h0FFE, 0, 16'h0000, 1'b1, 8'hFF, c0);
        fetch_one(8'hFF, 1, 16'h1230, 0, 16'h0000, 1'b0, 8'h00, c0);
        // Zero-latency response with ready high gives a 3-cycle instruction period.
        fetch_one(8'h00, 0, 16'h1230, 0, 16'h0000, 1'b0, 8'h01, c0);
        for (int i = 0; i < 8; i++) begin
            fetch_one(8'(1 + i), i, 16'h5000 + 16'(i * 16), int'($urandom_range(0, 3)),
                      16'h0000, 1'b0, 8'(2 + i), c1);
            if (i == 0) check("period", 32'(c1 - c0), 32'd3);
        end

        // Reset while waiting for a response; a late response must be ignored.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_req) found = 1;
        end
        check("mid_req_seen", 32'(found), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_mem_req", 32'(mem_req), 32'd0);
        check("mid_valid", 32'(instr_valid), 32'd0);
        check("mid_instr", 32'(instr), 32'd0);
        check("mid_ipc", 32'(instr_pc), 32'd0);
        check("mid_addr", 32'(mem_addr), 32'd0);
        check("mid_pc", 32'(pc), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 16'hDEAD;
        fetch_one(8'h00, 2, 16'h7770, 0, 16'h0000, 1'b0, 8'h01, c0);

        // Wrap from RESET_PC = 8'hFF with sequential words, zero-latency memory.
        nreq = 0;
        w_reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            w_mem_rvalid = w_mem_req;
            if (w_mem_req && nreq < 4) begin
                waddr[nreq] = w_mem_addr;
                nreq++;
            end
        end
        w_mem_rvalid = 1'b0;
        check("wrap_nreq", 32'(nreq), 32'd4);
        check("wrap_addr0", 32'(waddr[0]), 32'hFF);
        check("wrap_addr1", 32'(waddr[1]), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
